// File: rtl/grid_pkg.sv
// Shared grid constants, cell types, state encoding and cell-offset helper.
// Used by the grid editor and by the grid renderer.
package grid_pkg;

    localparam int DEF_SIZE_X    = 10;
    localparam int DEF_SIZE_Y    = 10;
    localparam int DEF_CELL_BITS = 1;

    localparam int CELL_EMPTY = 0;
    localparam int CELL_WALL  = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } edit_state_t;

    // Bit offset of cell (x,y) within the packed row-major grid vector.
    function automatic int cell_offset(input int x, input int y,
                                       input int size_x, input int cell_bits);
        return (y * size_x + x) * cell_bits;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level.
// Latency: pulse is combinational from the level against its registered history.
// Backpressure: none; history updates every cycle regardless of consumer state.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= btn;
        end
    end

    assign rise = btn & ~prev;

endmodule

// File: rtl/grid_editor.sv
// Grid editor: cursor with wrap-around, cell writes and a one-cell-per-cycle clear sweep.
// Latency: cursor/data update one cycle after a button edge; clear holds busy SIZE_X*SIZE_Y cycles.
// Backpressure: none; all button edges are dropped while busy. GRID_EDITOR_TOGGLE_EN makes set cycle the cell type.
module grid_editor
    import grid_pkg::*;
#(
    parameter int SIZE_X    = DEF_SIZE_X,
    parameter int SIZE_Y    = DEF_SIZE_Y,
    parameter int CELL_BITS = DEF_CELL_BITS,
    parameter int XBITS     = $clog2(SIZE_X),
    parameter int YBITS     = $clog2(SIZE_Y),
    parameter int GDBITS    = CELL_BITS * SIZE_X * SIZE_Y
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_set,
    input  logic                 btn_clear,
    input  logic [CELL_BITS-1:0] set_value,
    output logic [XBITS-1:0]     cursor_x,
    output logic [YBITS-1:0]     cursor_y,
    output logic [GDBITS-1:0]    data,
    output logic                 busy
);

    localparam int NCELLS   = SIZE_X * SIZE_Y;
    localparam int CNT_BITS = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam int IDX_BITS = $clog2(GDBITS) + 1;

    logic up_rise, down_rise, left_rise, right_rise, set_rise, clear_rise;

    btn_edge u_edge_up    (.clk(clk), .rst(rst), .btn(btn_up),    .rise(up_rise));
    btn_edge u_edge_down  (.clk(clk), .rst(rst), .btn(btn_down),  .rise(down_rise));
    btn_edge u_edge_left  (.clk(clk), .rst(rst), .btn(btn_left),  .rise(left_rise));
    btn_edge u_edge_right (.clk(clk), .rst(rst), .btn(btn_right), .rise(right_rise));
    btn_edge u_edge_set   (.clk(clk), .rst(rst), .btn(btn_set),   .rise(set_rise));
    btn_edge u_edge_clear (.clk(clk), .rst(rst), .btn(btn_clear), .rise(clear_rise));

    edit_state_t           state;
    logic [CNT_BITS-1:0]   sweep_cnt;
    logic [IDX_BITS-1:0]   set_idx;
    logic [IDX_BITS-1:0]   clr_idx;
    logic [CELL_BITS-1:0]  new_cell;
    logic [XBITS-1:0]      next_x;
    logic [YBITS-1:0]      next_y;

    always_comb begin
        set_idx = IDX_BITS'(cell_offset(int'(cursor_x), int'(cursor_y), SIZE_X, CELL_BITS));
        clr_idx = IDX_BITS'(int'(sweep_cnt) * CELL_BITS);
`ifdef GRID_EDITOR_TOGGLE_EN
        new_cell = data[set_idx +: CELL_BITS] + CELL_BITS'(1);
`else
        new_cell = set_value;
`endif
    end

    // Opposing edges in the same cycle cancel; each axis wraps independently.
    always_comb begin
        next_x = cursor_x;
        if (right_rise && !left_rise) begin
            next_x = (cursor_x == XBITS'(SIZE_X - 1)) ? '0 : cursor_x + XBITS'(1);
        end else if (left_rise && !right_rise) begin
            next_x = (cursor_x == '0) ? XBITS'(SIZE_X - 1) : cursor_x - XBITS'(1);
        end
        next_y = cursor_y;
        if (down_rise && !up_rise) begin
            next_y = (cursor_y == YBITS'(SIZE_Y - 1)) ? '0 : cursor_y + YBITS'(1);
        end else if (up_rise && !down_rise) begin
            next_y = (cursor_y == '0) ? YBITS'(SIZE_Y - 1) : cursor_y - YBITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            data      <= '0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_rise) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                        busy      <= 1'b1;
                    end else begin
                        // Set uses the pre-move cursor, so set+move writes the old cell.
                        if (set_rise) begin
                            data[set_idx +: CELL_BITS] <= new_cell;
                        end
                        cursor_x <= next_x;
                        cursor_y <= next_y;
                    end
                end
                CLEAR: begin
                    data[clr_idx +: CELL_BITS] <= CELL_BITS'(CELL_EMPTY);
                    if (sweep_cnt == CNT_BITS'(NCELLS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + CNT_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_editor.sv
// Scoreboarded bench for grid_editor: directed plan plus random button traffic
// against a cell-array reference model; expectations queued per clock, checked by a monitor.
module tb_grid_editor;

    localparam int SX = 10;
    localparam int SY = 10;
    localparam int CB = 2;
    localparam int GD = CB * SX * SY;

    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SET = 4, B_CLEAR = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           btn_up, btn_down, btn_left, btn_right, btn_set, btn_clear;
    logic [CB-1:0]  set_value;
    logic [3:0]     cursor_x;
    logic [3:0]     cursor_y;
    logic [GD-1:0]  data;
    logic           busy;

    grid_editor #(.SIZE_X(SX), .SIZE_Y(SY), .CELL_BITS(CB)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_set(btn_set), .btn_clear(btn_clear), .set_value(set_value),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .data(data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            x;
        int            y;
        logic          busy;
        logic [GD-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: plain cell array and integer cursor.
    int       grid[SX][SY];
    int       cx, cy;
    bit       in_clr;
    int       clr_k;
    bit [5:0] hist;

    task automatic chk(input string name, input logic [GD-1:0] act, input logic [GD-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic logic [GD-1:0] pack_grid();
        logic [GD-1:0] d = '0;
        for (int y = 0; y < SY; y++)
            for (int x = 0; x < SX; x++)
                d[(y * SX + x) * CB +: CB] = CB'(grid[x][y]);
        return d;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.x = cx; e.y = cy; e.busy = in_clr; e.data = pack_grid();
        return e;
    endfunction

    task automatic model_reset();
        for (int y = 0; y < SY; y++)
            for (int x = 0; x < SX; x++)
                grid[x][y] = 0;
        cx = 0; cy = 0; in_clr = 0; clr_k = 0; hist = '0;
    endtask

    task automatic model_apply(input bit [5:0] b, input int v);
        bit [5:0] rise = b & ~hist;
        hist = b;
        if (in_clr) begin
            grid[clr_k % SX][clr_k / SX] = 0;
            clr_k++;
            if (clr_k == SX * SY) in_clr = 0;
        end else if (rise[B_CLEAR]) begin
            in_clr = 1; clr_k = 0;
        end else begin
            if (rise[B_SET]) begin
`ifdef GRID_EDITOR_TOGGLE_EN
                grid[cx][cy] = (grid[cx][cy] + 1) % (1 << CB);
`else
                grid[cx][cy] = v;
`endif
            end
            cx = (cx + int'(rise[B_RIGHT]) - int'(rise[B_LEFT]) + SX) % SX;
            cy = (cy + int'(rise[B_DOWN])  - int'(rise[B_UP])   + SY) % SY;
        end
    endtask

    // Called at a falling edge: drive inputs, queue what the next rising edge must produce.
    task automatic step(input bit [5:0] b, input int v);
        btn_up = b[B_UP]; btn_down = b[B_DOWN]; btn_left = b[B_LEFT];
        btn_right = b[B_RIGHT]; btn_set = b[B_SET]; btn_clear = b[B_CLEAR];
        set_value = CB'(v);
        model_apply(b, v);
        exp_q.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic press(input bit [5:0] b, input int v);
        step(b, v);
        step(6'b0, v);
    endtask

    task automatic goto_cell(input int tx, input int ty);
        while (cx != tx) press(6'b1 << B_RIGHT, 0);
        while (cy != ty) press(6'b1 << B_DOWN, 0);
    endtask

    task automatic do_reset();
        exp_t e;
        rst = 1'b1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_set = 0; btn_clear = 0;
        set_value = '0;
        #1;
        model_reset();
        chk("rst_cursor_x", GD'(cursor_x), '0);
        chk("rst_cursor_y", GD'(cursor_y), '0);
        chk("rst_busy", GD'(busy), '0);
        chk("rst_data", data, '0);
        for (int i = 0; i < 2; i++) begin
            e = snapshot();
            exp_q.push_back(e);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    // Monitor: outputs are registered, so one expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("cursor_x", GD'(cursor_x), GD'(e.x));
                chk("cursor_y", GD'(cursor_y), GD'(e.y));
                chk("busy", GD'(busy), GD'(e.busy));
                chk("data", data, e.data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit [5:0] b;
        do_reset();

        for (int i = 0; i < 3; i++) press(6'b1 << B_RIGHT, 0);
        for (int i = 0; i < 2; i++) press(6'b1 << B_DOWN, 0);

        for (int i = 0; i < 3; i++) press(6'b1 << B_LEFT, 0);
        for (int i = 0; i < 2; i++) press(6'b1 << B_UP, 0);
        press(6'b1 << B_LEFT, 0);
        press(6'b1 << B_UP, 0);
        press((6'b1 << B_DOWN) | (6'b1 << B_RIGHT), 0);
        press((6'b1 << B_LEFT) | (6'b1 << B_RIGHT), 0);
        press((6'b1 << B_UP) | (6'b1 << B_DOWN), 0);

        goto_cell(4, 7);
        step(6'b1 << B_SET, 3);
        for (int i = 0; i < 5; i++) step(6'b1 << B_SET, 1);
        step(6'b0, 0);
        press((6'b1 << B_SET) | (6'b1 << B_RIGHT), 2);

        do_reset();
        goto_cell(1, 1);
        for (int i = 0; i < 5; i++) press(6'b1 << B_SET, i);

        do_reset();
        press(6'b1 << B_SET, 1);
        goto_cell(5, 5);
        press(6'b1 << B_SET, 2);
        goto_cell(9, 9);
        press(6'b1 << B_SET, 3);
        press((6'b1 << B_CLEAR) | (6'b1 << B_SET) | (6'b1 << B_LEFT), 1);
        for (int i = 0; i < 20; i++) step(6'b0, 0);
        press(6'b1 << B_SET, 3);
        for (int i = 0; i < 80; i++) step(6'b1 << B_RIGHT, 0);
        for (int i = 0; i < 3; i++) step(6'b0, 0);

        press(6'b1 << B_SET, 2);
        press(6'b1 << B_CLEAR, 0);
        for (int i = 0; i < 38; i++) step(6'b0, 0);
        do_reset();
        press(6'b1 << B_SET, 1);

        for (int i = 0; i < 600; i++) begin
            b = '0;
            for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 3) == 0);
            b[B_CLEAR] = ($urandom_range(0, 150) == 0);
            step(b, int'($urandom_range(0, 3)));
        end
        step(6'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
